// File: rtl/regfile_write_decode.sv
// regfile_write_decode: write-side decode and storage of the 32-entry register file with optional same-cycle forwarding
module regfile_write_decode #(
    parameter int WIDTH    = 32,
    parameter int ZERO_REG = 31,
    parameter bit BYPASS   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [4:0]             wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [31:0][WIDTH-1:0] regs_out,
    output logic [31:0]            wr_sel,
    output logic                   wr_done,
    output logic [4:0]             wr_done_addr
);
    logic [3:0] hi_sel;
    logic [7:0] lo_sel;
    logic       accept;
    logic       fwd;
    assign hi_sel = wr_en ? 4'(4'b0001 << wr_addr[4:3]) : 4'b0000;
    assign lo_sel = 8'(8'b0000_0001 << wr_addr[2:0]);
    assign accept = wr_en && (wr_addr != 5'(ZERO_REG));
    // a write dropped by reset is not forwarded either
    assign fwd    = BYPASS && accept && reset;
    genvar g, i;
    generate
        for (g = 0; g < 4; g++) begin : g_hi
            for (i = 0; i < 8; i++) begin : g_lo
                assign wr_sel[8*g+i] = hi_sel[g] & lo_sel[i];
            end
        end
        for (g = 0; g < 32; g++) begin : g_reg
            if (g == ZERO_REG) begin : g_zero
                assign regs_out[g] = '0;
            end else begin : g_store
                logic [WIDTH-1:0] q;
                always_ff @(posedge clk) begin
                    if (!reset)
                        q <= '0;
                    else if (wr_sel[g])
                        q <= wr_data;
                end
                assign regs_out[g] = (fwd && wr_sel[g]) ? wr_data : q;
            end
        end
    endgenerate
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_done      <= 1'b0;
            wr_done_addr <= 5'd0;
        end else begin
            wr_done <= accept;
            if (accept)
                wr_done_addr <= wr_addr;
        end
    end
endmodule

// File: tb/tb_regfile_write_decode.sv
// tb_regfile_write_decode: random and directed stimulus on a bypassing and a non-bypassing instance, checked against an array model
module tb_regfile_write_decode;
    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_en = 1'b0;
    logic [4:0]        wr_addr = '0;
    logic [31:0]       wr_data = '0;
    logic [31:0][31:0] regs_b, regs_n;
    logic [31:0]       sel_b, sel_n;
    logic              done_b, done_n;
    logic [4:0]        daddr_b, daddr_n;
    int                n_cmp = 0;
    int                n_bad = 0;
    logic [31:0]       m_regs [32];
    logic              m_done;
    logic [4:0]        m_daddr;
    bit                armed = 0;

    always #5 clk = ~clk;

    regfile_write_decode #(.WIDTH(32), .ZERO_REG(31), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .regs_out(regs_b), .wr_sel(sel_b), .wr_done(done_b), .wr_done_addr(daddr_b));
    regfile_write_decode #(.WIDTH(32), .ZERO_REG(31), .BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .regs_out(regs_n), .wr_sel(sel_n), .wr_done(done_n), .wr_done_addr(daddr_n));

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, idx, $time, act, exp);
        end
    endtask

    // model: registers are an array, a write lands at the edge unless reset or aimed at register 31
    always @(posedge clk) begin
        if (!reset) begin
            foreach (m_regs[k]) m_regs[k] = '0;
            m_done  = 0;
            m_daddr = '0;
            armed   = 1;
        end else if (wr_en && wr_addr != 5'd31) begin
            m_regs[wr_addr] = wr_data;
            m_done  = 1;
            m_daddr = wr_addr;
        end else begin
            m_done = 0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 32; k++) begin
                logic [31:0] eb;
                eb = (reset && wr_en && wr_addr == 5'(k) && k != 31) ? wr_data : m_regs[k];
                chk("regs_byp", k, regs_b[k], eb);
                chk("regs_nob", k, regs_n[k], m_regs[k]);
            end
            chk("wr_sel_byp", 0, sel_b, wr_en ? (32'd1 << wr_addr) : 32'd0);
            chk("wr_sel_nob", 0, sel_n, wr_en ? (32'd1 << wr_addr) : 32'd0);
            chk("wr_done_byp", 0, 32'(done_b), 32'(m_done));
            chk("wr_done_nob", 0, 32'(done_n), 32'(m_done));
            chk("wr_done_addr_byp", 0, 32'(daddr_b), 32'(m_daddr));
            chk("wr_done_addr_nob", 0, 32'(daddr_n), 32'(m_daddr));
        end
    end

    task automatic drv(input logic r, input logic e, input logic [4:0] a, input logic [31:0] d);
        reset = r; wr_en = e; wr_addr = a; wr_data = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held while a write is presented
        drv(0, 1, 5, 32'hDEADBEEF);
        tick(); tick();
        chk("rst_reg5_byp", 5, regs_b[5], 32'h0);
        chk("rst_reg5_nob", 5, regs_n[5], 32'h0);
        chk("rst_done", 0, 32'(done_b), 32'h0);
        drv(1, 0, 0, 0);
        tick();
        chk("post_rst_reg5", 5, regs_n[5], 32'h0);
        // walking write
        for (int k = 0; k < 32; k++) begin
            drv(1, 1, 5'(k), k == 31 ? 32'hFFFF_FFFF : 32'h1000_0000 + 32'(k));
            #1;
            chk("walk_sel", k, sel_n, 32'd1 << k);
            tick();
        end
        drv(1, 0, 0, 0);
        tick();
        chk("walk_reg0", 0, regs_n[0], 32'h1000_0000);
        chk("walk_reg17", 17, regs_n[17], 32'h1000_0011);
        chk("walk_reg30", 30, regs_n[30], 32'h1000_001E);
        chk("walk_reg31", 31, regs_b[31], 32'h0);
        chk("walk_daddr", 0, 32'(daddr_n), 32'd30);
        chk("walk_done", 0, 32'(done_n), 32'd0);
        // zero register under bypass
        drv(1, 1, 31, 32'h12345678);
        #1;
        chk("zero_same_cycle", 31, regs_b[31], 32'h0);
        tick();
        chk("zero_next_cycle", 31, regs_b[31], 32'h0);
        chk("zero_done", 0, 32'(done_b), 32'h0);
        // bypass timing on register 7
        drv(1, 1, 7, 32'hCAFEF00D);
        #1;
        chk("byp_during", 7, regs_b[7], 32'hCAFEF00D);
        chk("nob_during", 7, regs_n[7], 32'h1000_0007);
        tick();
        drv(1, 0, 0, 0);
        chk("byp_after", 7, regs_b[7], 32'hCAFEF00D);
        chk("nob_after", 7, regs_n[7], 32'hCAFEF00D);
        // same-index collision
        drv(1, 1, 3, 32'hA);
        tick();
        chk("coll_done1", 0, 32'(done_n), 32'd1);
        drv(1, 1, 3, 32'hB);
        tick();
        drv(1, 0, 0, 0);
        chk("coll_reg3", 3, regs_n[3], 32'hB);
        chk("coll_done2", 0, 32'(done_n), 32'd1);
        chk("coll_daddr", 0, 32'(daddr_n), 32'd3);
        // reset in the middle of a write burst
        drv(1, 1, 1, 32'h11);
        tick();
        drv(0, 1, 2, 32'h22);
        tick();
        drv(1, 1, 3, 32'h33);
        #1;
        chk("mid_done_after_rst", 0, 32'(done_n), 32'd0);
        chk("mid_reg1", 1, regs_n[1], 32'h0);
        chk("mid_reg2", 2, regs_n[2], 32'h0);
        tick();
        drv(1, 0, 0, 0);
        chk("mid_reg3", 3, regs_n[3], 32'h33);
        chk("mid_done", 0, 32'(done_n), 32'd1);
        chk("mid_daddr", 0, 32'(daddr_n), 32'd3);
        // random traffic, including idle cycles with garbage address/data
        for (int n = 0; n < 600; n++) begin
            drv($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, 5'($urandom), $urandom);
            tick();
        end
        drv(1, 0, 0, 0);
        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_write_decode.md
Name: regfile_write_decode

Overview:
- Write side of the 32x32 register file; the companion of the 32:1 read-port multiplexers.
- Decodes a 5-bit write address into 32 one-hot enables, gated by a write enable.
- Holds the 32 registers and presents all of them as a packed bus that feeds the read-port muxes.
- Register 31 is the hardwired zero register; it always reads 0.

Parameters:
- WIDTH, 32, data width of each register.
- ZERO_REG, 31, index of the hardwired-zero register; writes to it are discarded.
- BYPASS, 1, when 1 the write data is forwarded onto regs_out in the same cycle as the write.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- wr_en  input  1  write request for this cycle.
- wr_addr  input  5  destination register index, 0..31.
- wr_data  input  WIDTH  data to write.
- regs_out  output  [31:0][WIDTH-1:0]  packed contents of all registers; regs_out[i] is register i.
- wr_sel  output  32  one-hot decoded write enable for the current cycle (combinational); all 0 when wr_en=0.
- wr_done  output  1  registered pulse: 1 for one cycle after each accepted (committed) write.
- wr_done_addr  output  5  registered index of the last committed write; valid while wr_done=1.

Behaviour:
- Reset:
  - On a rising edge with reset=0, all 32 registers clear to 0, and wr_done and wr_done_addr clear to 0.
  - Reset takes priority over a simultaneous write; the write is dropped.
  - A write asserted during the reset cycle is lost. It is not replayed after reset releases.
- Decode:
  - wr_sel[k] = wr_en & (wr_addr == k). It is built hierarchically from a 2:4 decoder (wr_addr[4:3]) and 3:8 decoders (wr_addr[2:0]), mirroring the read-mux tree.
  - Exactly one bit of wr_sel is high when wr_en=1; all bits are low otherwise.
  - wr_sel[ZERO_REG] still asserts; suppression of the zero register happens in the storage.
- Commit:
  - At a rising edge with reset=1 and wr_sel[k]=1 and k != ZERO_REG, register k <= wr_data.
  - All other registers hold their value.
- Zero register: regs_out[ZERO_REG] is constant 0, both from reset and under any write or bypass.
- Latency:
  - A committed write is visible on regs_out from the cycle after the edge (1-cycle latency).
  - With BYPASS=1, regs_out[wr_addr] = wr_data combinationally during the write cycle itself, when wr_en=1 and wr_addr != ZERO_REG. All other entries show stored values.
  - With BYPASS=0, no forwarding occurs.
- wr_done / wr_done_addr:
  - At each edge with reset=1: wr_done <= wr_en & (wr_addr != ZERO_REG).
  - wr_done_addr <= wr_addr when that condition holds, otherwise it holds its value.
  - A write to ZERO_REG produces no wr_done pulse.
- Back-to-back writes:
  - Consecutive-cycle writes are each committed in order; no stall, no handshake; one write per cycle maximum.
  - Repeated writes to the same index: the last one wins.
  - wr_done stays high across consecutive accepted writes.
- X-safety: when wr_en=0, wr_addr and wr_data are don't-care and must not affect state or wr_sel.
- No combinational path from wr_addr or wr_data to wr_done or wr_done_addr.

Test Plan:
1. Reset: hold reset=0 for 2 cycles while wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF -> all regs_out=0, wr_done=0; register 5 is still 0 after release.
2. Walking write:
   - Stimulus: for k=0..30, write wr_data=32'h1000_0000+k to k on consecutive cycles, then for k=31 write 32'hFFFF_FFFF.
   - Response: regs_out[k]=32'h1000_0000+k for k<31, regs_out[31]=0; wr_done high for 31 cycles then low; wr_done_addr=30 at the end; wr_sel one-hot at every step.
3. Zero register under bypass: BYPASS=1, wr_en=1, wr_addr=31, wr_data=32'h12345678 -> regs_out[31]=0 in the same cycle and the next cycle; wr_done stays 0.
4. Bypass timing:
   - BYPASS=1: write 32'hCAFEF00D to register 7 -> regs_out[7]=32'hCAFEF00D during the write cycle and after it.
   - BYPASS=0: same write -> regs_out[7] keeps its old value during the cycle and updates on the next one.
5. Same-index collision: write 32'hA to reg 3, then 32'hB to reg 3 on the next cycle -> regs_out[3]=32'hB; wr_done is 1 for both cycles, wr_done_addr=3.
6. Reset mid-stream: writes to regs 1,2,3 on consecutive cycles with reset=0 asserted in the cycle of the reg-2 write -> regs 1,2,3=0 after release; wr_done=0 in the cycle after reset; the later reg-3 write (reset=1) commits normally.
